// File: rtl/axi_aw_w_sync.sv
// AXI write-channel synchronizer: forwards AW, queues burst lengths, gates W per burst and regenerates WLAST.
// Optional upstream-WLAST consistency check enabled by defining AXI_W_LAST_CHECK_EN.
module axi_aw_w_sync #(
  parameter int unsigned AW_WIDTH        = 32,
  parameter int unsigned W_WIDTH         = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   slv_aw_valid_i,
  output logic                                   slv_aw_ready_o,
  input  logic [7:0]                             slv_aw_len_i,
  input  logic [AW_WIDTH-1:0]                    slv_aw_data_i,
  output logic                                   mst_aw_valid_o,
  input  logic                                   mst_aw_ready_i,
  output logic [7:0]                             mst_aw_len_o,
  output logic [AW_WIDTH-1:0]                    mst_aw_data_o,
  input  logic                                   slv_w_valid_i,
  output logic                                   slv_w_ready_o,
  input  logic [W_WIDTH-1:0]                     slv_w_data_i,
  input  logic                                   slv_w_last_i,
  output logic                                   mst_w_valid_o,
  input  logic                                   mst_w_ready_i,
  output logic [W_WIDTH-1:0]                     mst_w_data_o,
  output logic                                   mst_w_last_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   error_o
);

  localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e          state_q;
  logic [7:0]      len_q [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [7:0]      beat_cnt_q;

  logic q_full;
  logic aw_push;
  logic in_burst;
  logic w_hs;
  logic w_pop;

  assign q_full   = (count_q == CW'(MAX_OUTSTANDING));

  assign mst_aw_valid_o = slv_aw_valid_i & ~q_full & ~rst_i;
  assign slv_aw_ready_o = mst_aw_ready_i & ~q_full & ~rst_i;
  assign mst_aw_len_o   = slv_aw_len_i;
  assign mst_aw_data_o  = slv_aw_data_i;
  assign aw_push        = mst_aw_valid_o & mst_aw_ready_i;

  // W is gated by the registered state, so it opens one cycle after the first AW lands.
  assign in_burst      = (state_q == BURST) & ~rst_i;
  assign mst_w_valid_o = in_burst & slv_w_valid_i;
  assign slv_w_ready_o = in_burst & mst_w_ready_i;
  assign mst_w_data_o  = slv_w_data_i;
  assign mst_w_last_o  = in_burst & (beat_cnt_q == len_q[rd_ptr_q]);
  assign w_hs          = mst_w_valid_o & mst_w_ready_i;
  assign w_pop         = w_hs & mst_w_last_o;

  assign outstanding_o = count_q;

  always_ff @(posedge clk_i) begin
    if (aw_push) begin
      len_q[wr_ptr_q] <= slv_aw_len_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (aw_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({aw_push, w_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (w_hs) begin
        beat_cnt_q <= w_pop ? '0 : beat_cnt_q + 8'd1;
      end
      case (state_q)
        IDLE:    if (aw_push) state_q <= BURST;
        BURST:   if (w_pop && !aw_push && count_q == CW'(1)) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AXI_W_LAST_CHECK_EN
  logic error_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      error_q <= 1'b0;
    end else if (w_hs && (slv_w_last_i != mst_w_last_o)) begin
      error_q <= 1'b1;
    end
  end

  assign error_o = error_q;
`else
  logic unused_w_last;
  assign unused_w_last = slv_w_last_i;
  assign error_o       = 1'b0;
`endif

endmodule

// File: tb/tb_axi_aw_w_sync.sv
// Directed self-checking bench for axi_aw_w_sync; inputs driven on the falling edge, outputs sampled 1ns later.
module tb_axi_aw_w_sync;

  localparam int unsigned AW_WIDTH        = 32;
  localparam int unsigned W_WIDTH         = 64;
  localparam int unsigned MAX_OUTSTANDING = 4;

`ifdef AXI_W_LAST_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                slv_aw_valid_i;
  logic                slv_aw_ready_o;
  logic [7:0]          slv_aw_len_i;
  logic [AW_WIDTH-1:0] slv_aw_data_i;
  logic                mst_aw_valid_o;
  logic                mst_aw_ready_i;
  logic [7:0]          mst_aw_len_o;
  logic [AW_WIDTH-1:0] mst_aw_data_o;
  logic                slv_w_valid_i;
  logic                slv_w_ready_o;
  logic [W_WIDTH-1:0]  slv_w_data_i;
  logic                slv_w_last_i;
  logic                mst_w_valid_o;
  logic                mst_w_ready_i;
  logic [W_WIDTH-1:0]  mst_w_data_o;
  logic                mst_w_last_o;
  logic [2:0]          outstanding_o;
  logic                error_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk_i = ~clk_i;

  axi_aw_w_sync #(
    .AW_WIDTH        (AW_WIDTH),
    .W_WIDTH         (W_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .slv_aw_valid_i (slv_aw_valid_i),
    .slv_aw_ready_o (slv_aw_ready_o),
    .slv_aw_len_i   (slv_aw_len_i),
    .slv_aw_data_i  (slv_aw_data_i),
    .mst_aw_valid_o (mst_aw_valid_o),
    .mst_aw_ready_i (mst_aw_ready_i),
    .mst_aw_len_o   (mst_aw_len_o),
    .mst_aw_data_o  (mst_aw_data_o),
    .slv_w_valid_i  (slv_w_valid_i),
    .slv_w_ready_o  (slv_w_ready_o),
    .slv_w_data_i   (slv_w_data_i),
    .slv_w_last_i   (slv_w_last_i),
    .mst_w_valid_o  (mst_w_valid_o),
    .mst_w_ready_i  (mst_w_ready_i),
    .mst_w_data_o   (mst_w_data_o),
    .mst_w_last_o   (mst_w_last_o),
    .outstanding_o  (outstanding_o),
    .error_o        (error_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge; callers then drive inputs and wait #1 before checking.
  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  logic [7:0] q_lens [4];
  logic       drain_last [10];

  initial begin
    q_lens     = '{8'd0, 8'd1, 8'd2, 8'd0};
    drain_last = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_i          = 1'b1;
    slv_aw_valid_i = 1'b0;
    slv_aw_len_i   = '0;
    slv_aw_data_i  = '0;
    mst_aw_ready_i = 1'b1;
    slv_w_valid_i  = 1'b0;
    slv_w_data_i   = '0;
    slv_w_last_i   = 1'b0;
    mst_w_ready_i  = 1'b1;

    // Reset state: outputs forced low while rst_i is held.
    next_cycle();
    slv_aw_valid_i = 1'b1;
    slv_w_valid_i  = 1'b1;
    #1;
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_mst_aw_valid", 64'(mst_aw_valid_o), 64'd0);
    chk("rst_slv_aw_ready", 64'(slv_aw_ready_o), 64'd0);
    chk("rst_mst_w_valid", 64'(mst_w_valid_o), 64'd0);
    chk("rst_error", 64'(error_o), 64'd0);
    next_cycle();
    rst_i          = 1'b0;
    slv_aw_valid_i = 1'b0;
    slv_w_valid_i  = 1'b0;

    // Single len=3 burst; W offered together with AW stalls one cycle.
    next_cycle();
    slv_aw_valid_i = 1'b1;
    slv_aw_len_i   = 8'd3;
    slv_aw_data_i  = 32'hA000_0003;
    slv_w_valid_i  = 1'b1;
    slv_w_data_i   = 64'h1111_0000_0000_0000;
    #1;
    chk("t1_mst_aw_valid", 64'(mst_aw_valid_o), 64'd1);
    chk("t1_slv_aw_ready", 64'(slv_aw_ready_o), 64'd1);
    chk("t1_aw_len", 64'(mst_aw_len_o), 64'd3);
    chk("t1_aw_data", 64'(mst_aw_data_o), 64'hA000_0003);
    chk("t1_w_stall", 64'(mst_w_valid_o), 64'd0);
    chk("t1_w_ready_stall", 64'(slv_w_ready_o), 64'd0);
    for (int b = 0; b < 4; b++) begin
      next_cycle();
      slv_aw_valid_i = 1'b0;
      slv_w_data_i   = 64'h1111_0000_0000_0000 + 64'(b);
      #1;
      if (b == 0) chk("t1_outstanding_1", 64'(outstanding_o), 64'd1);
      chk("t1_w_valid", 64'(mst_w_valid_o), 64'd1);
      chk("t1_w_last", 64'(mst_w_last_o), (b == 3) ? 64'd1 : 64'd0);
      chk("t1_w_data", mst_w_data_o, 64'h1111_0000_0000_0000 + 64'(b));
    end
    next_cycle();
    #1;
    chk("t1_outstanding_0", 64'(outstanding_o), 64'd0);
    chk("t1_w_valid_idle", 64'(mst_w_valid_o), 64'd0);

    // Fill the queue with W held off, then a fifth AW waits for the first pop.
    slv_w_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      slv_aw_valid_i = 1'b1;
      slv_aw_len_i   = q_lens[i];
      #1;
      chk("t2_fill_ready", 64'(slv_aw_ready_o), 64'd1);
    end
    next_cycle();
    slv_aw_len_i = 8'd5;
    #1;
    chk("t2_full_ready", 64'(slv_aw_ready_o), 64'd0);
    chk("t2_full_valid", 64'(mst_aw_valid_o), 64'd0);
    chk("t2_outstanding_4", 64'(outstanding_o), 64'd4);
    next_cycle();
    slv_w_valid_i = 1'b1;
    #1;
    chk("t2_still_full", 64'(slv_aw_ready_o), 64'd0);
    chk("t2_len0_last", 64'(mst_w_last_o), 64'd1);
    next_cycle();
    #1;
    chk("t2_ready_after_pop", 64'(slv_aw_ready_o), 64'd1);
    chk("t2_outstanding_3", 64'(outstanding_o), 64'd3);
    chk("t2_len1_b0_last", 64'(mst_w_last_o), 64'd0);
    next_cycle();
    slv_aw_valid_i = 1'b0;
    #1;
    chk("t2_outstanding_refill", 64'(outstanding_o), 64'd4);
    chk("t2_len1_b1_last", 64'(mst_w_last_o), 64'd1);
    for (int b = 0; b < 10; b++) begin
      next_cycle();
      #1;
      chk("t2_drain_valid", 64'(mst_w_valid_o), 64'd1);
      chk("t2_drain_last", 64'(mst_w_last_o), 64'(drain_last[b]));
    end
    next_cycle();
    slv_w_valid_i = 1'b0;
    #1;
    chk("t2_outstanding_0", 64'(outstanding_o), 64'd0);

    // Two len=1 bursts streamed back-to-back with no bubble.
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      slv_aw_valid_i = 1'b1;
      slv_aw_len_i   = 8'd1;
    end
    next_cycle();
    slv_aw_valid_i = 1'b0;
    slv_w_valid_i  = 1'b1;
    #1;
    chk("t3_outstanding_2", 64'(outstanding_o), 64'd2);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) next_cycle();
      #1;
      chk("t3_valid", 64'(mst_w_valid_o), 64'd1);
      chk("t3_last", 64'(mst_w_last_o), (b % 2 == 1) ? 64'd1 : 64'd0);
    end
    next_cycle();
    slv_w_valid_i = 1'b0;
    #1;
    chk("t3_outstanding_0", 64'(outstanding_o), 64'd0);

    // Max-length burst: 256 beats, last only on the final one.
    next_cycle();
    slv_aw_valid_i = 1'b1;
    slv_aw_len_i   = 8'd255;
    for (int b = 0; b < 256; b++) begin
      next_cycle();
      slv_aw_valid_i = 1'b0;
      slv_w_valid_i  = 1'b1;
      #1;
      chk("t4_last", 64'(mst_w_last_o), (b == 255) ? 64'd1 : 64'd0);
    end
    next_cycle();
    slv_w_valid_i = 1'b0;
    #1;
    chk("t4_outstanding_0", 64'(outstanding_o), 64'd0);

    // Early upstream WLAST on beat 2 of a len=2 burst.
    next_cycle();
    slv_aw_valid_i = 1'b1;
    slv_aw_len_i   = 8'd2;
    for (int b = 0; b < 3; b++) begin
      next_cycle();
      slv_aw_valid_i = 1'b0;
      slv_w_valid_i  = 1'b1;
      slv_w_last_i   = (b == 1);
      #1;
      if (b == 1) chk("t5_err_before", 64'(error_o), 64'd0);
      if (b == 2) chk("t5_err_set", 64'(error_o), 64'(EXP_ERR));
      chk("t5_last", 64'(mst_w_last_o), (b == 2) ? 64'd1 : 64'd0);
    end
    next_cycle();
    slv_w_valid_i = 1'b0;
    slv_w_last_i  = 1'b0;
    #1;
    chk("t5_err_sticky", 64'(error_o), 64'(EXP_ERR));
    chk("t5_outstanding_0", 64'(outstanding_o), 64'd0);

    // Reset in the middle of a len=7 burst, then a clean len=0 burst.
    next_cycle();
    slv_aw_valid_i = 1'b1;
    slv_aw_len_i   = 8'd7;
    next_cycle();
    slv_aw_valid_i = 1'b0;
    slv_w_valid_i  = 1'b1;
    #1;
    chk("t6_b0_last", 64'(mst_w_last_o), 64'd0);
    next_cycle();
    rst_i          = 1'b1;
    slv_aw_valid_i = 1'b1;
    #1;
    chk("t6_rst_w_valid", 64'(mst_w_valid_o), 64'd0);
    chk("t6_rst_w_ready", 64'(slv_w_ready_o), 64'd0);
    chk("t6_rst_w_last", 64'(mst_w_last_o), 64'd0);
    chk("t6_rst_aw_valid", 64'(mst_aw_valid_o), 64'd0);
    chk("t6_rst_aw_ready", 64'(slv_aw_ready_o), 64'd0);
    next_cycle();
    rst_i          = 1'b0;
    slv_aw_valid_i = 1'b0;
    #1;
    chk("t6_outstanding_0", 64'(outstanding_o), 64'd0);
    chk("t6_idle_w_valid", 64'(mst_w_valid_o), 64'd0);
    chk("t6_err_cleared", 64'(error_o), 64'd0);
    next_cycle();
    slv_aw_valid_i = 1'b1;
    slv_aw_len_i   = 8'd0;
    #1;
    chk("t6_new_aw_valid", 64'(mst_aw_valid_o), 64'd1);
    chk("t6_new_w_stall", 64'(mst_w_valid_o), 64'd0);
    next_cycle();
    slv_aw_valid_i = 1'b0;
    #1;
    chk("t6_new_outstanding_1", 64'(outstanding_o), 64'd1);
    chk("t6_new_valid", 64'(mst_w_valid_o), 64'd1);
    chk("t6_new_last", 64'(mst_w_last_o), 64'd1);
    next_cycle();
    slv_w_valid_i = 1'b0;
    #1;
    chk("t6_new_outstanding_0", 64'(outstanding_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_aw_w_sync.md
# axi_aw_w_sync

Write-channel synchronizer placed directly downstream of the AW and W channel slices, in front of a write-burst consumer. Forwards AW requests, records each burst length in an internal length queue, and releases W beats only for bursts whose AW has already been accepted downstream. Regenerates WLAST from the recorded AWLEN so the consumer always sees a correctly delimited burst.

## Interface
- AW_WIDTH, 32: width of packed AW payload excluding len (addr, id, size, burst, …)
- W_WIDTH, 64: width of packed W payload excluding last (data, strb, user)
- MAX_OUTSTANDING, 4: depth of length queue; power of two, ≥2
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  synchronous, active-high reset
- slv_aw_valid_i  input  1  upstream AW valid
- slv_aw_ready_o  output  1  upstream AW ready
- slv_aw_len_i  input  8  AWLEN (beats-1)
- slv_aw_data_i  input  AW_WIDTH  AW payload
- mst_aw_valid_o  output  1  downstream AW valid
- mst_aw_ready_i  input  1  downstream AW ready
- mst_aw_len_o  output  8  AWLEN passthrough
- mst_aw_data_o  output  AW_WIDTH  AW payload passthrough
- slv_w_valid_i  input  1  upstream W valid
- slv_w_ready_o  output  1  upstream W ready
- slv_w_data_i  input  W_WIDTH  W payload
- slv_w_last_i  input  1  upstream WLAST
- mst_w_valid_o  output  1  downstream W valid
- mst_w_ready_i  input  1  downstream W ready
- mst_w_data_o  output  W_WIDTH  W payload passthrough
- mst_w_last_o  output  1  regenerated WLAST
- outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  bursts queued, AW accepted, W not finished
- error_o  output  1  sticky WLAST mismatch flag

## Operation
- AW path combinational: mst_aw_valid_o = slv_aw_valid_i & ~q_full & ~rst_i; slv_aw_ready_o = mst_aw_ready_i & ~q_full & ~rst_i; len/data wired through.
- AW handshake (mst side) pushes slv_aw_len_i into length queue.
- States: IDLE (queue empty), BURST (queue non-empty). IDLE→BURST when queue becomes non-empty; BURST→IDLE when final beat pops last entry and no push same cycle.
- In BURST: mst_w_valid_o = slv_w_valid_i; slv_w_ready_o = mst_w_ready_i. In IDLE both 0. W data wired through.
- beat_cnt (8 bit) counts accepted beats of head burst; mst_w_last_o = BURST & (beat_cnt == q_head_len).
- W handshake: if mst_w_last_o, pop queue, beat_cnt←0; else beat_cnt←beat_cnt+1.
- Push and pop same cycle: both take effect, occupancy unchanged; full queue may push in a cycle where it pops only if ready is computed from registered full, i.e. no: ready uses q_full, push blocked when full even on simultaneous pop.
- outstanding_o = queue occupancy.
- Len 0 burst: single beat, last asserted on first beat. Len 255: 256 beats, counter never wraps past 255.

## Timing
- AW: zero-cycle latency passthrough.
- W enabled earliest one cycle after AW handshake into empty queue (registered occupancy); AW and W arriving same cycle into IDLE: AW passes, W stalls one cycle.
- Next burst's W beats may follow the previous last beat back-to-back (no bubble) if queue holds another entry.
- Reset (rst_i high at a clock edge): queue emptied, beat_cnt 0, state IDLE, error_o 0, outstanding_o 0; during rst_i all valid/ready outputs 0, mst_w_last_o 0. Reset mid-burst discards the burst; no partial state survives.

## Configuration
- AXI_W_LAST_CHECK_EN defined: on each W handshake, slv_w_last_i != mst_w_last_o sets error_o, held until reset; data flow unaffected (regenerated last wins).
- Not defined: slv_w_last_i ignored, error_o tied 0, no check logic.

## Test plan
- AW len=3 then 4 W beats, downstream ready=1 -> W enabled cycle after AW, mst_w_last_o on beat 4 only, outstanding 1→0.
- Four AWs (len 0,1,2,0) with W held off, fifth AW -> slv_aw_ready_o=0 for fifth until first burst's last beat pops; outstanding_o=4.
- Two queued bursts len=1, W streamed continuously -> 4 beats in 4 cycles, last on beats 2 and 4, no bubble.
- With AXI_W_LAST_CHECK_EN: len=2, upstream WLAST on beat 2 -> error_o=1 next cycle, stays 1; mst_w_last_o still on beat 3. Without macro error_o stays 0.
- Reset asserted mid-burst (beat 2 of len=7) -> next cycle outstanding_o=0, all valid/ready 0, new AW len=0 + 1 beat completes normally.
